ahbl_mst_arb: RTL and testbench

//  AHB-Lite arbiter/multiplexer sharing one AHB-Lite slave port between N_MST masters.
//  The slave port drives the ahb2apb bridge slave input.

---
 rtl/ahbl_mst_arb.sv | 128 ++++++++++++
 tb/tb_ahbl_mst_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_mst_arb.sv
// AHB-Lite master arbiter: shares one slave port between N_MST masters with
// round-robin grant that only moves while the current address owner is idle.
module ahbl_mst_arb #(
    parameter int unsigned N_MST = 2,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic [N_MST-1:0]     m_hsel,
    input  logic [N_MST*AW-1:0]  m_haddr,
    input  logic [N_MST*2-1:0]   m_htrans,
    input  logic [N_MST*3-1:0]   m_hsize,
    input  logic [N_MST*3-1:0]   m_hburst,
    input  logic [N_MST*4-1:0]   m_hprot,
    input  logic [N_MST-1:0]     m_hwrite,
    input  logic [N_MST*DW-1:0]  m_hwdata,
    output logic [DW-1:0]        m_hrdata,
    output logic [N_MST-1:0]     m_hready,
    output logic [N_MST-1:0]     m_hresp,
    output logic                 s_hsel,
    output logic [AW-1:0]        s_haddr,
    output logic [1:0]           s_htrans,
    output logic [2:0]           s_hsize,
    output logic [2:0]           s_hburst,
    output logic [3:0]           s_hprot,
    output logic                 s_hwrite,
    output logic [DW-1:0]        s_hwdata,
    input  logic [DW-1:0]        s_hrdata,
    input  logic                 s_hready,
    input  logic                 s_hresp,
    output logic [N_MST-1:0]     grant
);

    localparam int unsigned    IW          = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam logic [IW-1:0]  LAST        = IW'(N_MST - 1);
    localparam logic [1:0]     HTRANS_IDLE = 2'b00;

    logic [IW-1:0]    aown;
    logic [IW-1:0]    aown_nxt;
    logic [IW-1:0]    down;
    logic             dval;
    logic [N_MST-1:0] req;
    logic [1:0]       own_htrans;
    logic             owner_idle;
    logic             other_req;
    logic [IW-1:0]    scan_idx;
    logic [IW-1:0]    scan_win;

    always_comb begin
        req = '0;
        for (int unsigned m = 0; m < N_MST; m++) begin
            req[m] = m_hsel[m] & m_htrans[2*m+1];
        end
    end

    always_comb begin
        own_htrans = m_htrans[aown*2 +: 2];
        owner_idle = !m_hsel[aown] || (own_htrans == HTRANS_IDLE);
    end

    // Round-robin scan starting just after the current owner, wrapping modulo N_MST.
    always_comb begin
        other_req = 1'b0;
        scan_win  = aown;
        scan_idx  = aown;
        for (int unsigned i = 1; i < N_MST; i++) begin
            scan_idx = IW'((32'(aown) + i) % N_MST);
            if (!other_req && req[scan_idx]) begin
                other_req = 1'b1;
                scan_win  = scan_idx;
            end
        end
    end

    always_comb begin
        aown_nxt = aown;
        if (s_hready && owner_idle && other_req) begin
            aown_nxt = scan_win;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            aown <= LAST;
            down <= '0;
            dval <= 1'b0;
        end else begin
            aown <= aown_nxt;
            if (s_hready) begin
                down <= aown;
                dval <= s_hsel & s_htrans[1];
            end
        end
    end

    always_comb begin
        s_hsel   = m_hsel[aown] & ~hreset;
        s_htrans = hreset ? HTRANS_IDLE : own_htrans;
        s_haddr  = m_haddr[aown*AW +: AW];
        s_hsize  = m_hsize[aown*3 +: 3];
        s_hburst = m_hburst[aown*3 +: 3];
        s_hprot  = m_hprot[aown*4 +: 4];
        s_hwrite = m_hwrite[aown];
        s_hwdata = m_hwdata[down*DW +: DW];
        m_hrdata = s_hrdata;
    end

    always_comb begin
        grant    = '0;
        m_hready = '1;
        m_hresp  = '0;
        if (hreset) begin
            grant[LAST] = 1'b1;
        end else begin
            grant[aown] = 1'b1;
            for (int unsigned m = 0; m < N_MST; m++) begin
                if ((IW'(m) == aown) || (dval && (IW'(m) == down))) begin
                    m_hready[m] = s_hready;
                end else if (req[m]) begin
                    m_hready[m] = 1'b0;
                end
                m_hresp[m] = dval && (IW'(m) == down) && s_hresp;
            end
        end
    end

endmodule

// File: tb/tb_ahbl_mst_arb.sv
// Directed bench for ahbl_mst_arb with two masters; the bench plays the slave.
module tb_ahbl_mst_arb;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic            hclk;
    logic            hreset;
    logic [N-1:0]    m_hsel;
    logic [N*AW-1:0] m_haddr;
    logic [N*2-1:0]  m_htrans;
    logic [N*3-1:0]  m_hsize;
    logic [N*3-1:0]  m_hburst;
    logic [N*4-1:0]  m_hprot;
    logic [N-1:0]    m_hwrite;
    logic [N*DW-1:0] m_hwdata;
    logic [DW-1:0]   m_hrdata;
    logic [N-1:0]    m_hready;
    logic [N-1:0]    m_hresp;
    logic            s_hsel;
    logic [AW-1:0]   s_haddr;
    logic [1:0]      s_htrans;
    logic [2:0]      s_hsize;
    logic [2:0]      s_hburst;
    logic [3:0]      s_hprot;
    logic            s_hwrite;
    logic [DW-1:0]   s_hwdata;
    logic [DW-1:0]   s_hrdata;
    logic            s_hready;
    logic            s_hresp;
    logic [N-1:0]    grant;

    int checks   = 0;
    int failures = 0;

    ahbl_mst_arb #(.N_MST(N), .AW(AW), .DW(DW)) dut (
        .hclk(hclk), .hreset(hreset),
        .m_hsel(m_hsel), .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hsize(m_hsize),
        .m_hburst(m_hburst), .m_hprot(m_hprot), .m_hwrite(m_hwrite), .m_hwdata(m_hwdata),
        .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp),
        .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hsize(s_hsize),
        .s_hburst(s_hburst), .s_hprot(s_hprot), .s_hwrite(s_hwrite), .s_hwdata(s_hwdata),
        .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp),
        .grant(grant)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_m(input int idx, input logic sel, input logic [1:0] trans,
                         input logic [31:0] addr, input logic write, input logic [2:0] burst);
        m_hsel[idx]          = sel;
        m_htrans[idx*2 +: 2] = trans;
        m_haddr[idx*32 +: 32] = addr;
        m_hwrite[idx]        = write;
        m_hburst[idx*3 +: 3] = burst;
    endtask

    task automatic set_wdata(input int idx, input logic [31:0] d);
        m_hwdata[idx*32 +: 32] = d;
    endtask

    localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;

    initial begin
        hreset   = 1'b1;
        m_hsel   = '0;
        m_haddr  = '0;
        m_htrans = '0;
        m_hsize  = {3'd2, 3'd2};
        m_hburst = '0;
        m_hprot  = {4'd3, 4'd3};
        m_hwrite = '0;
        m_hwdata = '0;
        s_hrdata = '0;
        s_hready = 1'b1;
        s_hresp  = 1'b0;
        settle();
        chk("rst_htrans", s_htrans, 2'b00);
        chk("rst_hsel", s_hsel, 1'b0);
        chk("rst_hready", m_hready, 2'b11);
        chk("rst_grant", grant, 2'b10);
        chk("rst_hresp", m_hresp, 2'b00);
        tick();
        tick();
        hreset = 1'b0;
        settle();
        chk("post_rst_grant", grant, 2'b10);
        chk("post_rst_hready", m_hready, 2'b11);

        // 1: m0 alone, write then read
        set_m(0, 1'b1, NSEQ, 32'h100, 1'b1, 3'd0);
        settle();
        chk("t1_stall", m_hready, 2'b10);
        chk("t1_grant_pre", grant, 2'b10);
        tick();
        chk("t1_grant", grant, 2'b01);
        chk("t1_haddr", s_haddr, 32'h100);
        chk("t1_htrans", s_htrans, NSEQ);
        chk("t1_hwrite", s_hwrite, 1'b1);
        chk("t1_hsel", s_hsel, 1'b1);
        chk("t1_hsize", s_hsize, 3'd2);
        chk("t1_hprot", s_hprot, 4'd3);
        chk("t1_hready", m_hready, 2'b11);
        tick();
        set_m(0, 1'b1, NSEQ, 32'h100, 1'b0, 3'd0);
        set_wdata(0, 32'hA5A5_0001);
        settle();
        chk("t1_hwdata", s_hwdata, 32'hA5A5_0001);
        chk("t1_rd_haddr", s_haddr, 32'h100);
        chk("t1_rd_hwrite", s_hwrite, 1'b0);
        chk("t1_wr_hready", m_hready, 2'b11);
        tick();
        set_m(0, 1'b1, IDLE, 32'h100, 1'b0, 3'd0);
        s_hrdata = 32'h1234_5678;
        settle();
        chk("t1_hrdata", m_hrdata, 32'h1234_5678);
        chk("t1_rd_hready", m_hready, 2'b11);
        chk("t1_hresp", m_hresp, 2'b00);
        tick();

        // 2: simultaneous requests, m0 parked owner keeps the bus
        set_m(0, 1'b1, NSEQ, 32'h110, 1'b1, 3'd0);
        set_m(1, 1'b1, NSEQ, 32'h180, 1'b0, 3'd0);
        settle();
        chk("t2_hready", m_hready, 2'b01);
        chk("t2_grant", grant, 2'b01);
        tick();
        set_m(0, 1'b1, IDLE, 32'h110, 1'b1, 3'd0);
        set_wdata(0, 32'h0000_0110);
        settle();
        chk("t2_idle_hready", m_hready, 2'b01);
        chk("t2_idle_grant", grant, 2'b01);
        chk("t2_hwdata", s_hwdata, 32'h0000_0110);
        tick();
        chk("t2_grant_m1", grant, 2'b10);
        chk("t2_hready_m1", m_hready, 2'b11);
        chk("t2_haddr_m1", s_haddr, 32'h180);
        tick();

        // 3: m0 INCR4 with m1 requesting on beat 2
        set_m(1, 1'b0, IDLE, 32'h180, 1'b0, 3'd0);
        set_m(0, 1'b1, NSEQ, 32'h200, 1'b1, 3'd3);
        settle();
        chk("t3_stall_m0", m_hready, 2'b10);
        chk("t3_grant_pre", grant, 2'b10);
        tick();
        chk("t3_grant", grant, 2'b01);
        chk("t3_beat1", s_haddr, 32'h200);
        chk("t3_hburst", s_hburst, 3'd3);
        chk("t3_htrans1", s_htrans, NSEQ);
        tick();
        set_m(0, 1'b1, SEQ, 32'h204, 1'b1, 3'd3);
        set_m(1, 1'b1, NSEQ, 32'h300, 1'b0, 3'd0);
        settle();
        chk("t3_beat2", s_haddr, 32'h204);
        chk("t3_htrans2", s_htrans, SEQ);
        chk("t3_hready2", m_hready, 2'b01);
        chk("t3_grant2", grant, 2'b01);
        tick();
        set_m(0, 1'b1, SEQ, 32'h208, 1'b1, 3'd3);
        settle();
        chk("t3_beat3", s_haddr, 32'h208);
        chk("t3_grant3", grant, 2'b01);
        tick();
        set_m(0, 1'b1, SEQ, 32'h20C, 1'b1, 3'd3);
        settle();
        chk("t3_beat4", s_haddr, 32'h20C);
        chk("t3_hready4", m_hready, 2'b01);
        tick();
        set_m(0, 1'b0, IDLE, 32'h20C, 1'b1, 3'd0);
        settle();
        chk("t3_idle_grant", grant, 2'b01);
        chk("t3_idle_hready", m_hready, 2'b01);
        tick();
        chk("t3_grant_m1", grant, 2'b10);
        chk("t3_haddr_m1", s_haddr, 32'h300);
        chk("t3_hready_m1", m_hready, 2'b11);
        tick();

        // 4: two wait states on m0 write data phase
        set_m(1, 1'b0, IDLE, 32'h300, 1'b0, 3'd0);
        set_m(0, 1'b1, NSEQ, 32'h400, 1'b1, 3'd0);
        settle();
        chk("t4_stall_m0", m_hready, 2'b10);
        tick();
        chk("t4_haddr", s_haddr, 32'h400);
        tick();
        set_m(0, 1'b0, IDLE, 32'h400, 1'b1, 3'd0);
        set_wdata(0, 32'hDEAD_0004);
        set_m(1, 1'b1, NSEQ, 32'h500, 1'b0, 3'd0);
        s_hready = 1'b0;
        settle();
        chk("t4_ws1_hready", m_hready, 2'b00);
        chk("t4_ws1_hwdata", s_hwdata, 32'hDEAD_0004);
        chk("t4_ws1_grant", grant, 2'b01);
        tick();
        chk("t4_ws2_hready", m_hready, 2'b00);
        chk("t4_ws2_hwdata", s_hwdata, 32'hDEAD_0004);
        chk("t4_ws2_grant", grant, 2'b01);
        s_hready = 1'b1;
        settle();
        chk("t4_done_hready", m_hready, 2'b01);
        chk("t4_done_grant", grant, 2'b01);
        tick();
        chk("t4_grant_m1", grant, 2'b10);
        chk("t4_haddr_m1", s_haddr, 32'h500);

        // 5: two-cycle ERROR on m1 read, m0 waiting
        set_m(0, 1'b1, NSEQ, 32'h600, 1'b0, 3'd3);
        settle();
        chk("t5_stall_m0", m_hready, 2'b10);
        tick();
        set_m(1, 1'b0, IDLE, 32'h500, 1'b0, 3'd0);
        s_hready = 1'b0;
        s_hresp  = 1'b1;
        settle();
        chk("t5_err1_hresp", m_hresp, 2'b10);
        chk("t5_err1_hready", m_hready, 2'b00);
        chk("t5_err1_grant", grant, 2'b10);
        tick();
        s_hready = 1'b1;
        settle();
        chk("t5_err2_hresp", m_hresp, 2'b10);
        chk("t5_err2_hready", m_hready, 2'b10);
        chk("t5_err2_grant", grant, 2'b10);
        tick();
        s_hresp = 1'b0;
        settle();
        chk("t5_grant_m0", grant, 2'b01);
        chk("t5_haddr_m0", s_haddr, 32'h600);
        chk("t5_hresp_clr", m_hresp, 2'b00);

        // 6: reset in the middle of an INCR4
        tick();
        set_m(0, 1'b1, SEQ, 32'h604, 1'b0, 3'd3);
        settle();
        chk("t6_seq", s_htrans, SEQ);
        hreset  = 1'b1;
        s_hresp = 1'b1;
        settle();
        chk("t6_rst_htrans", s_htrans, IDLE);
        chk("t6_rst_hsel", s_hsel, 1'b0);
        chk("t6_rst_hready", m_hready, 2'b11);
        chk("t6_rst_grant", grant, 2'b10);
        chk("t6_rst_hresp", m_hresp, 2'b00);
        tick();
        chk("t6_rst2_htrans", s_htrans, IDLE);
        chk("t6_rst2_hready", m_hready, 2'b11);
        tick();
        hreset = 1'b0;
        set_m(0, 1'b0, IDLE, 32'h0, 1'b0, 3'd0);
        settle();
        chk("t6_rel_grant", grant, 2'b10);
        chk("t6_rel_hready", m_hready, 2'b11);
        chk("t6_rel_hresp", m_hresp, 2'b00);
        s_hresp = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
